load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Data-memory access stage fed by the multi-cycle core's EXECUTE step (core's MEMORY state).
//   Accepts one load/store request (funct3, byte address, store data).
//   Drives a synchronous-read, byte-masked data BRAM and returns the aligned, sign-/zero-extended load value.
//   Single outstanding request; the core stalls in MEMORY until done.
// PARAMETERS
//   DEPTH     128  data memory depth in 32-bit words; word index WA = $clog2(DEPTH) bits
//   MEM_LAT   1    BRAM read latency in cycles (only 1 supported; sanity-checked at elaboration)
// PORTS
//   clock      in   1      single clock, all state on posedge
//   reset      in   1      synchronous, active-high
//   req_valid  in   1      request strobe; sampled only in IDLE
//   req_store  in   1      1 = store, 0 = load
//   req_funct3 in   3      RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr   in   32     byte address (rs1 + imm from ALU)
//   req_wdata  in   32     rs2 value for stores
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle completion pulse
//   rsp_data   out  32     load result, valid only while done && !req_store_q, else 0
//   err        out  1      misalign/illegal-funct3 flag, valid with done (see CONFIGURATION)
//   mem_addr   out  WA     word address = addr_q[WA+1:2] (wraps modulo DEPTH)
//   mem_rd_en  out  1      BRAM read enable
//   mem_wmask  out  4      byte write enables; 0 = no write
//   mem_wdata  out  32     lane-replicated store data
//   mem_rdata  in   32     BRAM data, valid MEM_LAT cycles after mem_rd_en
// BEHAVIOUR
//   - Reset: state IDLE; busy=0, done=0, err=0, rsp_data=0, mem_rd_en=0, mem_wmask=0; mem_addr/mem_wdata=0.
//   - Accept on req_valid && state==IDLE at edge T: register addr, funct3, store, wdata.
//     req_valid while busy is ignored (not queued).
//   - FSM IDLE -> LD_WAIT -> LD_RESP -> IDLE (load).
//     IDLE -> ST_WRITE -> IDLE (store).
//     IDLE -> ERR -> IDLE (error, macro only).
//   - Load: cycle T+1 LD_WAIT asserts mem_rd_en.
//     Cycle T+2 LD_RESP: done=1, rsp_data = extract(mem_rdata).
//     Latency 2 cycles from accept; back-to-back accept possible at T+3.
//   - Extract: byte lane = addr_q[1:0]; half lane = addr_q[1]; word = full.
//     LB/LH sign-extend, LBU/LHU zero-extend.
//   - Store: cycle T+1 ST_WRITE, done=1.
//     SB: wmask = 4'b0001 << addr_q[1:0], wdata = {4{wdata_q[7:0]}}.
//     SH: wmask = addr_q[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata_q[15:0]}}.
//     SW: wmask = 4'b1111.
//   - Illegal funct3 (load 011/110/111, store >=011): no memory access; completes at T+1 with done=1, rsp_data=0.
//   - mem_wmask and mem_rd_en gated by !reset: reset asserted in ST_WRITE/LD_WAIT issues no access.
//     Next cycle is IDLE; done is never pulsed for the aborted request.
//   - done and mem_* are combinational decodes of registered state and request fields; no combinational path from req_* to mem_*.
// CONFIGURATION
//   LSU_MISALIGN_TRAP_EN defined:
//     - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, goes to ERR at T+1.
//     - No mem access; done=1, err=1, rsp_data=0.
//     - Illegal funct3 also sets err=1.
//   Not defined:
//     - err tied 0.
//     - Misaligned halves use addr[1]; misaligned words ignore addr[1:0] (natural-alignment truncation).
//     - Access proceeds normally.
// STRUCTURE
//   lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), lsu_state_t enum {IDLE, LD_WAIT, LD_RESP, ST_WRITE, ERR}, misalign function.
//   Sub-module lsu_load_align (combinational: rdata, lane, funct3 -> extended result); the rest stays in load_store_unit.
// TESTING (BRAM model preloaded word 4 = 32'h8765_43A1)
//   1. LB addr 0x10 -> done at T+2, rsp_data 32'hFFFF_FFA1, mem_addr 4, mem_rd_en only at T+1.
//   2. LBU addr 0x13 -> rsp_data 32'h0000_0087.
//      LH 0x12 -> 32'hFFFF_8765.
//      LHU 0x10 -> 32'h0000_43A1.
//   3. SB wdata 32'h1234_565A addr 0x21 -> T+1: mem_wmask 4'b0010, mem_wdata 32'h5A5A_5A5A, mem_addr 8, done=1.
//      Read-back LW 0x20 shows byte 1 = 8'h5A.
//   4. LW 0x11 -> with LSU_MISALIGN_TRAP_EN: done T+1, err=1, mem_rd_en never high.
//      Without the macro: rsp_data 32'h8765_43A1, err=0.
//   5. req_valid held high during a load -> exactly one access; next accept at T+3.
//      SW to addr 4*DEPTH writes word 0 (wrap).
//   6. Reset asserted in ST_WRITE -> mem_wmask 0 that cycle, memory unchanged, IDLE next, no done pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// request classification helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      LD_WAIT,
      LD_RESP,
      ST_WRITE,
      ERR
   } lsu_state_t;

   // Halfwords need an even address, words a 4-byte aligned one.
   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] lane);
      logic mis;
      mis = 1'b0;
      case (funct3)
         F3_H, F3_HU: mis = lane[0];
         F3_W:        mis = (lane != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic illegal_funct3(input logic store, input logic [2:0] funct3);
      if (store) begin
         return (funct3 > F3_W);
      end
      return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the addressed byte/half/word out of a
// BRAM word and sign- or zero-extends it according to funct3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
      half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result_o = {24'h0, byte_sel};
         F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result_o = {16'h0, half_sel};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit driving a 1-cycle synchronous byte-masked BRAM.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned halves/words complete with err).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DEPTH   = 128,
   parameter int MEM_LAT = 1,
   localparam int WA     = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_valid,
   input  logic          req_store,
   input  logic [2:0]    req_funct3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          busy,
   output logic          done,
   output logic [31:0]   rsp_data,
   output logic          err,
   output logic [WA-1:0] mem_addr,
   output logic          mem_rd_en,
   output logic [3:0]    mem_wmask,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   if (MEM_LAT != 1) begin : g_bad_mem_lat
      $error("load_store_unit supports MEM_LAT == 1 only");
   end

   lsu_state_t    state_q, state_d;
   logic [WA+1:0] addr_q;
   logic [2:0]    funct3_q;
   logic          store_q;
   logic [31:0]   wdata_q;
   logic          accept;
   logic          req_bad;
   logic [31:0]   load_result;
   logic          unused_addr_hi;

   // Bytes above the memory window only alias, so they are not stored.
   assign unused_addr_hi = ^req_addr[31:WA+2];
   assign accept         = req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_bad = illegal_funct3(req_store, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
   assign req_bad = illegal_funct3(req_store, req_funct3);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         funct3_q <= '0;
         store_q  <= 1'b0;
         wdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q   <= req_addr[WA+1:0];
            funct3_q <= req_funct3;
            store_q  <= req_store;
            wdata_q  <= req_wdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_bad)        state_d = ERR;
               else if (req_store) state_d = ST_WRITE;
               else                state_d = LD_WAIT;
            end
         end
         LD_WAIT:  state_d = LD_RESP;
         LD_RESP:  state_d = IDLE;
         ST_WRITE: state_d = IDLE;
         ERR:      state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   lsu_load_align u_load_align (
      .rdata_i  (mem_rdata),
      .lane_i   (addr_q[1:0]),
      .funct3_i (funct3_q),
      .result_o (load_result)
   );

   // Completion and memory strobes are masked by reset so an aborted request
   // neither touches memory nor reports completion.
   always_comb begin
      busy      = (state_q != IDLE);
      done      = !reset && ((state_q == LD_RESP) || (state_q == ST_WRITE) || (state_q == ERR));
      mem_rd_en = !reset && (state_q == LD_WAIT);
      rsp_data  = (!reset && (state_q == LD_RESP) && !store_q) ? load_result : 32'h0;
      mem_addr  = addr_q[WA+1:2];
      mem_wmask = 4'b0000;
      case (funct3_q)
         F3_B:    mem_wdata = {4{wdata_q[7:0]}};
         F3_H:    mem_wdata = {2{wdata_q[15:0]}};
         default: mem_wdata = wdata_q;
      endcase
      if (!reset && (state_q == ST_WRITE)) begin
         case (funct3_q)
            F3_B:    mem_wmask = 4'b0001 << addr_q[1:0];
            F3_H:    mem_wmask = addr_q[1] ? 4'b1100 : 4'b0011;
            F3_W:    mem_wmask = 4'b1111;
            default: mem_wmask = 4'b0000;
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign err = !reset && (state_q == ERR);
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed steps plus random traffic
// checked against a byte-addressed reference memory model.
module tb_load_store_unit;

   localparam int DEPTH = 128;
   localparam int WA    = $clog2(DEPTH);
   localparam int NBYTE = 4 * DEPTH;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_store = 1'b0;
   logic [2:0]    req_funct3 = 3'b0;
   logic [31:0]   req_addr = 32'h0;
   logic [31:0]   req_wdata = 32'h0;
   logic          busy, done, err, mem_rd_en;
   logic [31:0]   rsp_data, mem_wdata;
   logic [WA-1:0] mem_addr;
   logic [3:0]    mem_wmask;
   logic [31:0]   mem_rdata = 32'h0;

   int checks   = 0;
   int failures = 0;

   load_store_unit #(.DEPTH(DEPTH), .MEM_LAT(1)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .done(done), .rsp_data(rsp_data), .err(err),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   // BRAM model: image loaded while preload is high, then byte-masked writes.
   logic [31:0] bram [DEPTH];
   logic [31:0] img  [DEPTH];
   logic        preload = 1'b1;

   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) bram[i] <= img[i];
      end else begin
         for (int k = 0; k < 4; k++)
            if (mem_wmask[k]) bram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
      if (mem_rd_en) mem_rdata <= bram[mem_addr];
   end

   // Reference memory as plain bytes, little-endian.
   logic [7:0] ref_b [NBYTE];

   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit is_illegal(input bit st, input logic [2:0] f3);
      if (st) return f3 > 3'd2;
      return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

   function automatic int base_of(input logic [2:0] f3, input logic [31:0] addr);
      int a;
      a = int'(addr & (NBYTE - 1));
      return a - (a % size_of(f3));
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
      int n, b;
      logic [31:0] v;
      n = size_of(f3);
      b = base_of(f3, addr);
      v = 32'h0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_b[b + k]) << (8 * k));
      if (n < 4 && !f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction starting in an IDLE cycle; ends one cycle after completion (IDLE again).
   task automatic xact(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold, output logic [31:0] got);
      bit errpath;
      int n, b;
      logic [3:0]    emask;
      logic [31:0]   ewd, exp;
      logic [WA-1:0] ewa;
      n = size_of(f3);
      b = base_of(f3, addr);
      errpath = is_illegal(st, f3) || (TRAP && (int'(addr[1:0]) % n != 0));
      ewa = WA'(int'(addr & (NBYTE - 1)) / 4);
      got = 32'h0;
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clock); #1;
      if (!hold) req_valid = 1'b0;
      if (errpath) begin
         chk("err_done", 32'(done), 32'd1);
         chk("err_flag", 32'(err), 32'(TRAP));
         chk("err_rsp", rsp_data, 32'h0);
         chk("err_noacc", {27'h0, mem_rd_en, mem_wmask}, 32'h0);
      end else if (st) begin
         emask = 4'b0;
         for (int k = 0; k < n; k++) emask[(b % 4) + k] = 1'b1;
         ewd = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;
         chk("st_done", 32'(done), 32'd1);
         chk("st_wmask", 32'(mem_wmask), 32'(emask));
         chk("st_wdata", mem_wdata, ewd);
         chk("st_addr", 32'(mem_addr), 32'(ewa));
         chk("st_rd_en", 32'(mem_rd_en), 32'd0);
         chk("st_err", 32'(err), 32'd0);
         for (int k = 0; k < n; k++) ref_b[b + k] = wdata[8*k +: 8];
      end else begin
         exp = ref_load(f3, addr);
         chk("ld_wait_rd_en", 32'(mem_rd_en), 32'd1);
         chk("ld_wait_done", 32'(done), 32'd0);
         chk("ld_wait_busy", 32'(busy), 32'd1);
         chk("ld_wait_wmask", 32'(mem_wmask), 32'd0);
         chk("ld_addr", 32'(mem_addr), 32'(ewa));
         @(posedge clock); #1;
         chk("ld_done", 32'(done), 32'd1);
         chk("ld_rsp", rsp_data, exp);
         chk("ld_resp_rd_en", 32'(mem_rd_en), 32'd0);
         chk("ld_err", 32'(err), 32'd0);
         got = rsp_data;
      end
      if (errpath || st) got = rsp_data;
      @(posedge clock); #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_rd_en", 32'(mem_rd_en), 32'd0);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] r;
      for (int i = 0; i < DEPTH; i++) begin
         r = (i == 4) ? 32'h8765_43A1 : $urandom;
         img[i] = r;
         for (int k = 0; k < 4; k++) ref_b[4*i + k] = r[8*k +: 8];
      end

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rsp", rsp_data, 32'h0);
      chk("rst_strobes", {27'h0, mem_rd_en, mem_wmask}, 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      reset = 1'b0; preload = 1'b0;
      @(posedge clock); #1;

      // Directed loads from the preloaded word
      xact(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, got); chk("dir_lb_10", got, 32'hFFFF_FFA1);
      xact(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, got); chk("dir_lbu_13", got, 32'h0000_0087);
      xact(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, got); chk("dir_lh_12", got, 32'hFFFF_8765);
      xact(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, got); chk("dir_lhu_10", got, 32'h0000_43A1);

      // Byte store and read-back
      xact(1'b1, 3'b000, 32'h21, 32'h1234_565A, 1'b0, got);
      xact(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, got); chk("dir_sb_readback", 32'(got[15:8]), 32'h5A);

      // Misaligned word load
      xact(1'b0, 3'b010, 32'h11, 32'h0, 1'b0, got);
      chk("dir_lw_11", got, TRAP ? 32'h0 : 32'h8765_43A1);

      // req_valid held through a load: second accept only at T+3
      xact(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, got);
      @(posedge clock); #1;
      chk("hold_reaccept_busy", 32'(busy), 32'd1);
      chk("hold_reaccept_rd_en", 32'(mem_rd_en), 32'd1);
      req_valid = 1'b0;
      @(posedge clock); #1;
      chk("hold_second_rsp", rsp_data, ref_load(3'b010, 32'h10));
      @(posedge clock); #1;

      // Wrap: 4*DEPTH maps to word 0
      xact(1'b1, 3'b010, 32'(NBYTE), 32'hCAFE_F00D, 1'b0, got);
      xact(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, got); chk("wrap_readback", got, 32'hCAFE_F00D);

      // Illegal funct3 for load and store
      xact(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, got);
      xact(1'b1, 3'b100, 32'h10, 32'h0, 1'b0, got);

      // Reset asserted while in ST_WRITE aborts the store
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
      @(posedge clock); #1;
      req_valid = 1'b0;
      reset = 1'b1; #1;
      chk("abort_wmask", 32'(mem_wmask), 32'h0);
      chk("abort_done", 32'(done), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0; #1;
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_no_done", 32'(done), 32'd0);
      @(posedge clock); #1;
      xact(1'b0, 3'b010, 32'h30, 32'h0, 1'b0, got);

      // Random traffic against the reference model
      for (int t = 0; t < 80; t++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) a = a | ($urandom << 9);
         xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0, got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
